// File: rtl/ss_display_pkg.sv
// ---------------------------------------------------------------------------
// ss_display_pkg
// Shared definitions for the keyboard-adder display path.
//   - Glyph codes understood by SS_display_ultra (dash, 'U', blank).
//   - The word shown after reset or for a zero result: blank digits, one "0".
//   - The state encoding of the binary-to-BCD formatter FSM.
// No ports; imported with "import ss_display_pkg::*;".
// ---------------------------------------------------------------------------
package ss_display_pkg;

    // Display glyph codes; values 0-9 are plain decimal digits
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_U     = 4'hB;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Seven blank digits followed by a single zero in digit 0
    localparam logic [31:0] BCD_ZERO = 32'hFFFF_FFF0;

    // Formatter control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FORMAT = 2'd2
    } fmt_state_t;

endpackage

// File: rtl/bcd_add3_cell.sv
// ---------------------------------------------------------------------------
// bcd_add3_cell
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added so that the following left shift carries correctly into
// the next decimal digit.
// Ports:
//   digit_i  4-bit BCD digit before correction
//   digit_o  4-bit corrected digit
// ---------------------------------------------------------------------------
module bcd_add3_cell (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Adding 3 before the doubling is the same as adding 6 after it, which
    // is the decimal carry adjustment for digits that would exceed 9
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_formatter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_formatter
// Iterative shift-add-3 binary-to-BCD converter plus display formatter for
// the keyboard adder. One operand bit is consumed per clock; once all bits
// are shifted in, the BCD digits are blanked, signed and overflow-marked and
// the finished word is published on data_BCD together with a done pulse.
// data_BCD and overflow hold the previous result while a conversion runs.
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      single-cycle request, only honoured while idle
//   value      operand, captured on the accepted start edge
//   is_signed  1 = two's-complement operand, 0 = unsigned
//   busy       high from the cycle after acceptance until done
//   done       one-cycle pulse when data_BCD updates
//   overflow   1 = last result did not fit on the display
//   data_BCD   eight glyph codes, digit 7 in the top nibble
// ---------------------------------------------------------------------------
module bin_to_bcd_formatter
    import ss_display_pkg::*;
#(
    parameter int          WIDTH          = 25,
    parameter int unsigned MAX_SIGNED_MAG = 9999999,
    parameter int unsigned MAX_UNSIGNED   = 99999999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [31:0]      data_BCD
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    fmt_state_t       state_q;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] mag_d;
    logic [31:0]      bcd_q;
    logic [31:0]      bcd_d;
    logic [31:0]      corrected;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [31:0]      data_q;

    logic             cap_neg;
    logic [WIDTH-1:0] cap_mag;
    logic [31:0]      cap_ext;
    logic             cap_ovf;

    logic [2:0]       msd;
    logic             found;
    logic [31:0]      formatted;

    // Operand capture: sign, magnitude and range check are all decided from
    // the input word itself, so the overflow verdict never depends on BCD
    // digits that may have run past eight nibbles
    always_comb begin
        cap_neg = is_signed & value[WIDTH-1];
        cap_mag = cap_neg ? (-value) : value;
        cap_ext = {{(32 - WIDTH){1'b0}}, cap_mag};
        if (cap_neg || is_signed) begin
            cap_ovf = (cap_ext > MAX_SIGNED_MAG);
        end else begin
            cap_ovf = (cap_ext > MAX_UNSIGNED);
        end
    end

    // Add-3 correction on all eight digits ahead of each shift
    for (genvar g = 0; g < 8; g++) begin : g_add3
        bcd_add3_cell u_cell (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (corrected[4*g +: 4])
        );
    end

    // One double-dabble step: the magnitude MSB enters the BCD LSB
    assign {bcd_d, mag_d} = {corrected, mag_q} << 1;

    // Display formatting. The scan walks digits 7..1 and stops at the first
    // nonzero one; everything above it is blanked and, for negatives, the
    // digit directly above it becomes the dash. Overflow and zero override
    // the scanned result.
    always_comb begin
        msd       = 3'd0;
        found     = 1'b0;
        formatted = bcd_q;
        for (int i = 7; i >= 1; i--) begin
            if (!found && (bcd_q[4*i +: 4] != 4'd0)) begin
                msd   = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = 1; i < 8; i++) begin
            if (3'(i) > msd) begin
                formatted[4*i +: 4] = DIG_BLANK;
            end
        end
        if (neg_q && (msd != 3'd7)) begin
            formatted[4*(int'(msd) + 1) +: 4] = DIG_DASH;
        end
        if (ovf_q) begin
            formatted = {8{DIG_DASH}};
        end else if (bcd_q == 32'd0) begin
            formatted = BCD_ZERO;
        end
    end

    // Control FSM with registered outputs. Reset abandons any conversion in
    // flight and restores the zero display. A start seen outside IDLE is
    // dropped, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            data_q     <= BCD_ZERO;
            bcd_q      <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        neg_q   <= cap_neg;
                        ovf_q   <= cap_ovf;
                        mag_q   <= cap_mag;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FORMAT;
                    end
                end
                FORMAT: begin
                    data_q     <= formatted;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign data_BCD = data_q;

endmodule

// File: tb/tb_bin_to_bcd_formatter.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_formatter
// Directed bench for bin_to_bcd_formatter at WIDTH=25. Each conversion is
// followed cycle by cycle: done must stay low and the previous word must
// hold for 25 cycles, then done pulses with the hand-computed word.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_formatter;

    localparam int WIDTH = 25;
    localparam logic [31:0] RESET_WORD = 32'hFFFF_FFF0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             is_signed = 1'b0;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [31:0]      data_BCD;

    int          total = 0;
    int          bad = 0;
    logic [31:0] heldData = RESET_WORD;
    logic        heldOvf = 1'b0;

    // 10 ns clock
    always #5 clk = ~clk;

    bin_to_bcd_formatter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .data_BCD  (data_BCD)
    );

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present an operand with a one-cycle start pulse
    task automatic applyStimulus(input int v, input logic sgn);
        value     = v[WIDTH-1:0];
        is_signed = sgn;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Full conversion; extraAt>0 pulses start again in that cycle of the run
    task automatic runConv(input string tag, input int v, input logic sgn,
                           input logic [31:0] expData, input logic expOvf,
                           input int extraAt);
        applyStimulus(v, sgn);
        checkOutput({tag, ":busy_start"}, 32'(busy), 32'd1);
        checkOutput({tag, ":done_start"}, 32'(done), 32'd0);
        for (int i = 1; i <= WIDTH; i++) begin
            start = (i == extraAt);
            tick();
            start = 1'b0;
            checkOutput({tag, ":done_early"}, 32'(done), 32'd0);
            checkOutput({tag, ":busy_run"}, 32'(busy), 32'd1);
            checkOutput({tag, ":data_hold"}, data_BCD, heldData);
            checkOutput({tag, ":ovf_hold"}, 32'(overflow), 32'(heldOvf));
        end
        tick();
        checkOutput({tag, ":done"}, 32'(done), 32'd1);
        checkOutput({tag, ":busy_end"}, 32'(busy), 32'd0);
        checkOutput({tag, ":data"}, data_BCD, expData);
        checkOutput({tag, ":ovf"}, 32'(overflow), 32'(expOvf));
        heldData = expData;
        heldOvf  = expOvf;
        tick();
        checkOutput({tag, ":done_after"}, 32'(done), 32'd0);
        checkOutput({tag, ":busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, ":data_after"}, data_BCD, expData);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst:data", data_BCD, RESET_WORD);
        checkOutput("rst:busy", 32'(busy), 32'd0);
        checkOutput("rst:done", 32'(done), 32'd0);
        checkOutput("rst:ovf", 32'(overflow), 32'd0);

        // Main conversions
        runConv("u1234", 1234, 1'b0, 32'hFFFF_1234, 1'b0, 0);
        runConv("s-56", -56, 1'b1, 32'hFFFF_FA56, 1'b0, 0);
        runConv("s-9999999", -9999999, 1'b1, 32'hA999_9999, 1'b0, 0);
        runConv("s0", 0, 1'b1, 32'hFFFF_FFF0, 1'b0, 0);
        runConv("s10M", 10000000, 1'b1, 32'hAAAA_AAAA, 1'b1, 0);
        runConv("u10M", 10000000, 1'b0, 32'h1000_0000, 1'b0, 0);
        runConv("u33554431", 33554431, 1'b0, 32'h3355_4431, 1'b0, 0);
        runConv("s-1", -1, 1'b1, 32'hFFFF_FFA1, 1'b0, 0);

        // Start while busy is ignored
        runConv("u42_restart", 42, 1'b0, 32'hFFFF_FF42, 1'b0, 5);

        // Reset in the middle of a conversion
        applyStimulus(777, 1'b0);
        for (int i = 1; i < 10; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst:data", data_BCD, RESET_WORD);
        checkOutput("midrst:busy", 32'(busy), 32'd0);
        checkOutput("midrst:done", 32'(done), 32'd0);
        checkOutput("midrst:ovf", 32'(overflow), 32'd0);
        heldData = RESET_WORD;
        heldOvf  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checkOutput("midrst:no_done", 32'(done), 32'd0);
        end
        runConv("after_rst", 5, 1'b0, 32'hFFFF_FFF5, 1'b0, 0);

        // Start together with reset: reset wins
        value     = 25'd9;
        is_signed = 1'b0;
        rst       = 1'b1;
        start     = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_start:busy", 32'(busy), 32'd0);
        checkOutput("rst_start:data", data_BCD, RESET_WORD);
        tick();
        checkOutput("rst_start:busy2", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
